w_controller: RTL and testbench



---
 rtl/fifo_ctrl_pkg.sv | 27 ++
 rtl/fifo_occupancy.sv | 72 +++++++
 rtl/w_controller.sv | 92 +++++++++
 tb/tb_w_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared definitions for the FIFO write-side controller.
//   - STATE_W     : width of the write FSM state register
//   - wstate_e    : write FSM state encoding (Idle=0, Write=1, HS=2; 3 unused)
//   - clog2()     : ceiling log2, used to cross-check ADDR_W against DEPTH
package fifo_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HS    = 2'd2
    } wstate_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// fifo_occupancy: read/write pointers, occupancy count and full/empty flags.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   push        : one entry committed this cycle (write FSM is in Write)
//   rd_pop      : one-cycle pop pulse from the read controller
//   wr_addr     : write pointer
//   rd_addr     : read pointer
//   count       : occupancy, 0..DEPTH
//   full, empty : decoded from the registered count
module fifo_occupancy #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              rd_pop,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              pop_ok;

    // A pop against an empty FIFO is dropped entirely.
    assign pop_ok = rd_pop && !empty;

    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        if (push) begin
            // Natural ADDR_W-bit rollover gives the mod-DEPTH wrap.
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        // Simultaneous push and pop leave the count unchanged.
        case ({push, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
        end
    end

    assign wr_addr = wr_addr_q;
    assign rd_addr = rd_addr_q;
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);

endmodule

// File: rtl/w_controller.sv
// w_controller: write-side controller for the small synchronous FIFO.
// Handshake: the producer raises write_en and holds it until it sees ack;
// ack stays high (Write, then HS) until write_en drops, and the FSM only
// returns to Idle once write_en is low, so one write_en assertion yields
// exactly one write. wr_ld is a one-cycle storage load strobe at wr_addr.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   write_en   : producer write request
//   rd_pop     : one-cycle pop pulse from the read controller
//   wr_ld      : storage load strobe (high only in Write)
//   wr_addr    : write pointer
//   rd_addr    : read pointer
//   ack        : handshake acknowledge (Write and HS)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
//   dbg_state  : current FSM state, for observation
module w_controller
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic               rd_pop,
    output logic               wr_ld,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               ack,
    output logic [ADDR_W:0]    count,
    output logic               full,
    output logic               empty,
    output logic [STATE_W-1:0] dbg_state
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != clog2(DEPTH)) begin : g_bad_param
        $error("w_controller: DEPTH must be a power of two >= 2 and ADDR_W = clog2(DEPTH)");
    end

    wstate_e state_q, state_d;
    logic    push;

    always_comb begin
        state_d = ST_IDLE;
        wr_ld   = 1'b0;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Uses registered full only: a same-cycle pop does not admit a write.
                state_d = (write_en && !full) ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                wr_ld   = 1'b1;
                ack     = 1'b1;
                state_d = write_en ? ST_HS : ST_IDLE;
            end
            ST_HS: begin
                ack     = 1'b1;
                state_d = write_en ? ST_HS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign push      = (state_q == ST_WRITE);
    assign dbg_state = state_q;

    fifo_occupancy #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_occupancy (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .rd_pop  (rd_pop),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_w_controller.sv
module tb_w_controller;
    import fifo_ctrl_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               write_en = 1'b0;
    logic               rd_pop = 1'b0;
    logic               wr_ld;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic               ack;
    logic [ADDR_W:0]    count;
    logic               full;
    logic               empty;
    logic [STATE_W-1:0] dbg_state;

    logic [ADDR_W-1:0] exp_q[$];
    int n_vec   = 0;
    int n_err   = 0;
    int ld_seen = 0;

    w_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .rd_pop    (rd_pop),
        .wr_ld     (wr_ld),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .ack       (ack),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Every load strobe outside reset must match the next expected address.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_ld === 1'b1) begin
            ld_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wr_ld: wr_addr=%0d, no write expected", wr_addr);
            end else begin
                check("wr_ld_addr", int'(wr_addr), int'(exp_q.pop_front()));
                check("wr_ld_ack", int'(ack), 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; write_en = 1'b0; rd_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: ack=0 after 20 cycles, required 1");
        end
    endtask

    // One handshake; write_en drops as soon as ack is seen. With pop_with
    // set, rd_pop is pulsed in the same cycle as the Write state.
    task automatic do_write(input logic [ADDR_W-1:0] exp_addr, input bit pop_with);
        bit ok;
        exp_q.push_back(exp_addr);
        @(posedge clk); #1 write_en = 1'b1;
        wait_ack(ok);
        write_en = 1'b0;
        if (pop_with) rd_pop = 1'b1;
        @(posedge clk); #1 rd_pop = 1'b0;
    endtask

    task automatic pulse_pop();
        @(posedge clk); #1 rd_pop = 1'b1;
        @(posedge clk); #1 rd_pop = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int ld0;

        // Reset
        do_reset();
        @(negedge clk);
        check("rst_wr_ld",   int'(wr_ld),     0);
        check("rst_ack",     int'(ack),       0);
        check("rst_wr_addr", int'(wr_addr),   0);
        check("rst_rd_addr", int'(rd_addr),   0);
        check("rst_count",   int'(count),     0);
        check("rst_full",    int'(full),      0);
        check("rst_empty",   int'(empty),     1);
        check("rst_state",   int'(dbg_state), 0);

        // Single write, dropped on ack
        do_write(3'd0, 1'b0);
        @(negedge clk);
        check("single_count",   int'(count),     1);
        check("single_wr_addr", int'(wr_addr),   1);
        check("single_empty",   int'(empty),     0);
        check("single_state",   int'(dbg_state), 0);

        // Held write_en: exactly one load, FSM parks in HS
        exp_q.push_back(3'd1);
        ld0 = ld_seen;
        @(posedge clk); #1 write_en = 1'b1;
        wait_ack(ok);
        repeat (3) @(negedge clk);
        check("held_state_hs", int'(dbg_state), 2);
        check("held_ack",      int'(ack),       1);
        check("held_wr_ld",    int'(wr_ld),     0);
        check("held_ld_count", ld_seen - ld0,   1);
        check("held_count",    int'(count),     2);
        @(posedge clk); #1 write_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("held_release_state", int'(dbg_state), 0);
        check("held_release_ack",   int'(ack),       0);

        // Fill and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 1'b0);
        @(negedge clk);
        check("fill_full",    int'(full),    1);
        check("fill_count",   int'(count),   8);
        check("fill_wr_addr", int'(wr_addr), 0);
        check("fill_empty",   int'(empty),   0);

        // Ninth request waits in Idle while full
        @(posedge clk); #1 write_en = 1'b1;
        repeat (3) @(negedge clk);
        check("full_wait_ack",   int'(ack),       0);
        check("full_wait_state", int'(dbg_state), 0);

        // One pop frees a slot; the pending write commits at wr_addr 0
        exp_q.push_back(3'd0);
        pulse_pop();
        @(negedge clk);
        check("pop_count",   int'(count),     7);
        check("pop_rd_addr", int'(rd_addr),   1);
        check("pop_full",    int'(full),      0);
        check("pop_state",   int'(dbg_state), 0);
        wait_ack(ok);
        write_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("refill_count",   int'(count),   8);
        check("refill_wr_addr", int'(wr_addr), 1);
        check("refill_full",    int'(full),    1);

        // Simultaneous push and pop at count 3
        do_reset();
        for (int i = 0; i < 3; i++) do_write(ADDR_W'(i), 1'b0);
        @(negedge clk);
        check("sim_pre_count", int'(count), 3);
        do_write(3'd3, 1'b1);
        @(negedge clk);
        check("sim_count",   int'(count),   3);
        check("sim_wr_addr", int'(wr_addr), 4);
        check("sim_rd_addr", int'(rd_addr), 1);

        // Underflow: pop while empty is ignored
        do_reset();
        pulse_pop();
        @(negedge clk);
        check("under_rd_addr", int'(rd_addr), 0);
        check("under_count",   int'(count),   0);
        check("under_empty",   int'(empty),   1);

        // Reset during the Write cycle: no commit
        @(posedge clk); #1 write_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rstw_in_write", int'(dbg_state), 1);
        write_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_count",   int'(count),     0);
        check("rstw_wr_addr", int'(wr_addr),   0);
        check("rstw_state",   int'(dbg_state), 0);
        check("rstw_ack",     int'(ack),       0);
        check("rstw_empty",   int'(empty),     1);

        // Final report
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
